// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO-to-serial drain block:
// FSM encoding, frame length and default bit timing.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 4;
  localparam int FRAME_BITS_DEF   = DATA_W_DEF + 2;

  function automatic int frame_bits(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/fifo_tx_drain_baud.sv
// Bit-period counter: tick marks the last clock of a bit,
// pre_tick the clock before it.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || tick) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick     = (r_cnt == LAST);
  assign pre_tick = (r_cnt == PRE);

endmodule

// File: rtl/fifo_tx_drain.sv
// Pops the FIFO head whenever it is non-empty and sends it
// as a start/8-data/stop serial frame, LSB first.
module fifo_tx_drain
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = 5,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              en_out,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [2:0]        state
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [2:0]        r_bit, w_bit_next;
  logic              r_en_out, r_tx, r_busy, r_done;
  logic              w_tx_next, w_done_next;
  logic              w_tick, w_pre, w_clr;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .tick    (w_tick),
    .pre_tick(w_pre)
  );

  always_comb begin
    w_next       = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    unique case (r_state)
      S_IDLE:  if (en && fifo_count != '0) w_next = S_POP;
      S_POP: begin
        w_shift_next = fifo_dout;
        w_bit_next   = '0;
        w_next       = S_START;
      end
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == BIT_LAST) w_next = S_STOP;
        end
      end
      S_STOP:  if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state so the flops line up with it
  always_comb begin
    w_clr       = (w_next != r_state);
    w_tx_next   = 1'b1;
    w_done_next = (r_state == S_STOP) && w_pre;
    if (w_next == S_START)     w_tx_next = 1'b0;
    else if (w_next == S_DATA) w_tx_next = w_shift_next[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_en_out <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_shift  <= w_shift_next;
      r_bit    <= w_bit_next;
      r_en_out <= (w_next == S_POP);
      r_tx     <= w_tx_next;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= w_done_next;
    end
  end

  assign en_out  = r_en_out;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;
  assign state   = r_state;

endmodule

// File: doc/fifo_tx_drain.md
# fifo_tx_drain

Reader-side companion to the lab-2 8-bit queue. Whenever the queue reports a non-zero `count`, it pops the head entry with a single-cycle `en_out` pulse and latches `dout`. It then transmits the byte on a one-wire, UART-style serial line (start bit, 8 data bits LSB first, stop bit). It sits between the FIFO outputs and the board's serial/LED pin, so queued data drains autonomously without button presses.

## Interface
Parameters:
- `DATA_W`, 8: payload width; must match the FIFO data width.
- `CNT_W`, 5: width of the FIFO occupancy count (0..16 entries).
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; ≥2. Board builds override it.

Ports:
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: drain enable; sampled only in IDLE.
- `fifo_dout`  in  DATA_W: FIFO head entry; valid whenever `fifo_count != 0`.
- `fifo_count`  in  CNT_W: FIFO occupancy.
- `en_out`  out  1: pop request to the FIFO; one-cycle pulse.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high from the POP cycle through the last STOP cycle.
- `tx_done`  out  1: one-cycle pulse in the final cycle of STOP.
- `state`  out  3: current FSM state, for debug display.

## Operation
- FSM states, encoded in order: IDLE=0, POP=1, START=2, DATA=3, STOP=4.
- IDLE → POP when `en && fifo_count != 0`; otherwise stay in IDLE.
- POP lasts exactly 1 cycle:
  - `en_out`=1.
  - shift register ← `fifo_dout`, sampled before the FIFO advances.
  - bit counter ← 0.
  - → START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then → DATA.
- DATA:
  - `tx` = shift[0].
  - Each bit is held for CLKS_PER_BIT cycles; at the end of each bit the register shifts right and the bit counter increments.
  - After bit DATA_W−1 → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles; `tx_done`=1 in the last of these cycles; then → IDLE.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Cleared on entry to START, DATA and STOP, and at every bit boundary.
  - A bit ends when the counter reaches CLKS_PER_BIT−1.
- `en` dropping mid-frame: the current frame completes; no new pop is issued.
- `fifo_count` changing mid-frame (writes to the FIFO): ignored until IDLE.
- FIFO empty in IDLE: no pop; `tx` stays high.
- A popped byte is always transmitted in full unless `rst` is asserted.

## Timing
- Reset values: state=IDLE, `en_out`=0, `tx`=1, `busy`=0, `tx_done`=0, shift register=0, counters=0.
- `rst` mid-frame: next cycle is IDLE with `tx`=1. The byte being sent is lost; the FIFO is not re-read.
- `rst` has priority over all other inputs.
- All outputs are registered.
- Latency:
  - `en_out` rises 1 cycle after the IDLE cycle in which the pop condition holds.
  - `tx` falls on the cycle after POP.
- Frame occupancy: `busy` high for 1 + (DATA_W+2)·CLKS_PER_BIT cycles, i.e. 41 at the defaults.
- Back-to-back frames: at least one IDLE cycle between STOP and the next POP. This guarantees `en_out` is low ≥ (DATA_W+2)·CLKS_PER_BIT+1 cycles between pulses, which is compatible with the FIFO's edge-detected `en_out`.
- `en_out` is never asserted when `fifo_count` sampled in IDLE was 0, so an underflow pop is impossible.

## Structure
- Shared package `fifo_tx_pkg`:
  - state encoding constants (IDLE..STOP, 3 bits);
  - the frame-length constant `(DATA_W+2)`;
  - default `CLKS_PER_BIT`.
- One sub-module, `baud_tick`:
  - Parameter: CLKS_PER_BIT.
  - Inputs: `clk`, `rst`, `clr`.
  - Output: `tick` when the count reaches CLKS_PER_BIT−1.
  - The top-level FSM drives `clr` on state entry.
- Rest of the top level: FSM, shift register, 3-bit bit counter, output registers.

## Test plan
Benches use CLKS_PER_BIT=4, DATA_W=8 and a behavioural FIFO model (`dout` = head; advances on a rising edge of `en_out`).
- **Single byte.** FIFO holds 0x53, `en`=1.
  - One `en_out` pulse, then `tx` bits 0,1,1,0,0,1,0,1,0,1, each 4 cycles.
  - `tx_done` fires once; `busy` is high for 41 cycles; FIFO count goes 1→0.
- **Two entries.** FIFO holds 0xA5 then 0x0F.
  - Two frames (bits 1,0,1,0,0,1,0,1 then 1,1,1,1,0,0,0,0).
  - Exactly one IDLE cycle between frames; `en_out` pulses are 42 cycles apart.
- **Empty FIFO.** Count=0 with `en`=1 for 50 cycles.
  - `en_out` never asserts; `tx`=1; state=0 throughout.
- **Enable drop.** `en` falls mid-DATA with 3 entries queued.
  - The current frame completes; no further `en_out`; FIFO count stays at 2.
- **Reset mid-frame.** `rst` for 1 cycle during DATA bit 3.
  - Next cycle: `tx`=1, `busy`=0, state=IDLE.
  - With `en`=1 and count≠0, a new POP follows in the cycle after IDLE.
- **Reset idle.** `rst` held 10 cycles with FIFO non-empty.
  - All outputs hold reset values; no `en_out` pulse while `rst`=1.
